array_result_drain: RTL and testbench
=====================================

# array_result_drain

Downstream stage of the 4x4 sparse systolic array. Accepts the array's 16 column-chain partial-sum outputs once per pass and accumulates them across the passes of one output tile. On the tile's last pass it applies a rounding right-shift requantization with unsigned saturation to DATA_WIDTH. It then drains the tile as ARRAY_SIZE beats over a valid/ready stream toward the activation write-back buffer.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one requantized output lane
- BLOCK_SIZE, 4, outputs per cell (per column chain)
- ARRAY_SIZE, 4, number of array columns = number of drain beats
- ACC_WIDTH, 4*DATA_WIDTH, width of array outputs and accumulators (unsigned)
- SHIFT_WIDTH, 5, width of requant shift amount

Ports:
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  reset: one clock; reset is synchronous and active-high
- In_valid  in  1  partial-sum vector valid
- In_ready  out  1  block can accept a pass
- In_data  in  BLOCK_SIZE*ARRAY_SIZE*ACC_WIDTH  flattened array output; lane i = bits [i*ACC_WIDTH +: ACC_WIDTH], lane i = output index i of the array (column c owns lanes 4c..4c+3)
- In_last  in  1  qualifies In_data as the final pass of the tile
- Shift  in  SHIFT_WIDTH  requant right-shift, sampled with the In_last beat
- Out_valid  out  1  drain beat valid
- Out_ready  in  1  consumer accepts beat
- Out_data  out  BLOCK_SIZE*DATA_WIDTH  lanes of column Out_index; lane l = bits [l*DATA_WIDTH +: DATA_WIDTH]
- Out_index  out  $clog2(ARRAY_SIZE)  column number of current beat
- Out_last  out  1  high on final beat (Out_index = ARRAY_SIZE-1)
- Overflow  out  1  some accumulator saturated during the current tile

## Operation
- States: ACCUM, DRAIN.
- ACCUM: In_ready=1, Out_valid=0. A pass is accepted when In_valid & In_ready.
  - First pass of a tile (first flag set): acc[i] <= In_data lane i. Overflow <= 0. First flag cleared.
  - Later passes: acc[i] <= acc[i] + lane i, computed in ACC_WIDTH+1 bits. On carry out, acc[i] <= 2^ACC_WIDTH-1 and Overflow <= 1.
  - Pass with In_last=1: accumulate as above, latch Shift into shift_r, beat <= 0, go to DRAIN.
- DRAIN: In_ready=0, Out_valid=1. Out_index = beat. Out_last = (beat == ARRAY_SIZE-1).
  - Out_data lane l = requant(acc[beat*BLOCK_SIZE + l]).
  - Beat completes on Out_valid & Out_ready. Non-last beat: beat+1. Last beat: go to ACCUM, set first flag.
- Requant(a), in ACC_WIDTH+1 bits:
  - shift_r = 0: r = a.
  - otherwise: r = (a + 2^(shift_r-1)) >> shift_r (round half up).
  - Output = min(r, 2^DATA_WIDTH-1).
- Accumulators and shift_r are frozen during DRAIN, so Out_data is stable while Out_valid=1.
- A tile may consist of a single pass: first pass with In_last=1.

## Timing
- Reset values: state=ACCUM, first flag=1, beat=0, acc=0, shift_r=0, Overflow=0. Outputs after reset: In_ready=1, Out_valid=0, Out_last=0, Out_index=0, Out_data=0.
- Pass throughput: 1 per cycle in ACCUM.
- Latency: In_last accepted at edge N gives Out_valid=1 in the cycle after edge N. The first beat can complete at edge N+1.
- Drain: minimum ARRAY_SIZE cycles. In_ready returns to 1 in the cycle after the last beat completes. Minimum tile-to-tile gap is ARRAY_SIZE cycles of In_ready=0.
- Backpressure: while Out_ready=0, Out_data, Out_index and Out_last hold; no beat is skipped or duplicated.
- In_valid during DRAIN is ignored (In_ready=0). Upstream holds its data.
- Overflow is registered. It holds its value through DRAIN and clears only on the next first-pass accept or Rst.
- Rst in any state takes priority. The partially accumulated or partially drained tile is discarded, and all registers return to their reset values at that edge.

## Test plan
- Single pass, In_last=1, lane i = 16*i, Shift=0 -> 4 beats; beat c lanes = 16*(4c+l); Out_last only on beat 3; Overflow=0.
- Three passes of lane value 100, last with Shift=2 -> every output lane = 75 (302>>2). Out_valid rises exactly one cycle after the third accept.
- Rounding/saturation: single-pass lanes {5,6,1023,0}, Shift=2 -> {1,2,255,0}. Separately, Shift=0 with lane 300 -> 255.
- Accumulator overflow: pass 1 lane0 = 0xFFFFFFF0, pass 2 lane0 = 0x20 -> acc0 = 0xFFFFFFFF, Overflow=1, output 255. The next tile's first pass clears Overflow to 0.
- Backpressure: Out_ready=0 for 3 cycles at beat 1 -> Out_index=1 and Out_data held constant, In_ready=0 throughout. The remaining beats 2,3 follow in order once Out_ready=1.
- Reset mid-drain: assert Rst during beat 2 -> next cycle Out_valid=0, In_ready=1, Overflow=0. A following single pass of all-7 with Shift=0 drains all lanes = 7, with no residue from the aborted tile.

Source files
------------

// File: rtl/array_result_drain.sv
// Result drain for the 4x4 sparse systolic array: accumulates per-pass partial sums,
// requantizes on the last pass and streams the tile out one column per beat.
module array_result_drain #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BLOCK_SIZE  = 4,
  parameter int unsigned ARRAY_SIZE  = 4,
  parameter int unsigned ACC_WIDTH   = 4 * DATA_WIDTH,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                                     Clk,
  input  logic                                     Rst,
  input  logic                                     In_valid,
  output logic                                     In_ready,
  input  logic [BLOCK_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] In_data,
  input  logic                                     In_last,
  input  logic [SHIFT_WIDTH-1:0]                   Shift,
  output logic                                     Out_valid,
  input  logic                                     Out_ready,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]         Out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]            Out_index,
  output logic                                     Out_last,
  output logic                                     Overflow
);

  localparam int unsigned LANES = BLOCK_SIZE * ARRAY_SIZE;
  localparam int unsigned ACC1  = ACC_WIDTH + 1;
  localparam int unsigned IDX_W = $clog2(ARRAY_SIZE);
  localparam logic [ACC1-1:0]  SAT       = ACC1'({DATA_WIDTH{1'b1}});
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(ARRAY_SIZE - 1);

  typedef enum logic {S_ACCUM, S_DRAIN} state_t;

  state_t                          r_state, w_state_nxt;
  logic                            r_first, w_first_nxt;
  logic [IDX_W-1:0]                r_beat, w_beat_nxt;
  logic [ACC_WIDTH-1:0]            r_acc [LANES];
  logic [ACC_WIDTH-1:0]            w_acc_nxt [LANES];
  logic [ACC1-1:0]                 w_sum [LANES];
  logic [SHIFT_WIDTH-1:0]          r_shift, w_shift_nxt;
  logic                            r_overflow, w_ovf_nxt;
  logic                            r_in_ready, r_out_valid, r_out_last;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;

  // Round-half-up right shift, then unsigned clamp to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [SHIFT_WIDTH-1:0] s);
    logic [ACC1-1:0] r;
    if (s == '0) r = ACC1'(a);
    else         r = (ACC1'(a) + (ACC1'(1) << (s - SHIFT_WIDTH'(1)))) >> s;
    if (r > SAT) return '1;
    return r[DATA_WIDTH-1:0];
  endfunction

  always_comb begin : p_sum
    for (int i = 0; i < int'(LANES); i++)
      w_sum[i] = ACC1'(r_acc[i]) + ACC1'(In_data[i*ACC_WIDTH +: ACC_WIDTH]);
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_first_nxt = r_first;
    w_beat_nxt  = r_beat;
    w_shift_nxt = r_shift;
    w_ovf_nxt   = r_overflow;
    w_acc_nxt   = r_acc;
    w_out_data_nxt = '0;

    case (r_state)
      S_ACCUM: begin
        if (In_valid) begin
          // First pass of a tile overwrites; later passes add with saturation.
          w_ovf_nxt   = r_first ? 1'b0 : r_overflow;
          w_first_nxt = 1'b0;
          for (int i = 0; i < int'(LANES); i++) begin
            if (r_first) begin
              w_acc_nxt[i] = In_data[i*ACC_WIDTH +: ACC_WIDTH];
            end else if (w_sum[i][ACC_WIDTH]) begin
              w_acc_nxt[i] = '1;
              w_ovf_nxt    = 1'b1;
            end else begin
              w_acc_nxt[i] = w_sum[i][ACC_WIDTH-1:0];
            end
          end
          if (In_last) begin
            w_shift_nxt = Shift;
            w_beat_nxt  = '0;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (Out_ready) begin
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = S_ACCUM;
            w_first_nxt = 1'b1;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_ACCUM;
    endcase

    // Output lanes are precomputed for the beat that will be presented next cycle.
    if (w_state_nxt == S_DRAIN) begin
      for (int l = 0; l < int'(BLOCK_SIZE); l++)
        w_out_data_nxt[l*DATA_WIDTH +: DATA_WIDTH] =
          requant(w_acc_nxt[int'(w_beat_nxt)*int'(BLOCK_SIZE) + l], w_shift_nxt);
    end
  end

  always_ff @(posedge Clk) begin : p_regs
    if (Rst) begin
      r_state     <= S_ACCUM;
      r_first     <= 1'b1;
      r_beat      <= '0;
      r_shift     <= '0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < int'(LANES); i++) r_acc[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_first     <= w_first_nxt;
      r_beat      <= w_beat_nxt;
      r_shift     <= w_shift_nxt;
      r_overflow  <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt == S_ACCUM);
      r_out_valid <= (w_state_nxt == S_DRAIN);
      r_out_last  <= (w_state_nxt == S_DRAIN) && (w_beat_nxt == LAST_BEAT);
      r_out_data  <= w_out_data_nxt;
      for (int i = 0; i < int'(LANES); i++) r_acc[i] <= w_acc_nxt[i];
    end
  end

  assign In_ready  = r_in_ready;
  assign Out_valid = r_out_valid;
  assign Out_last  = r_out_last;
  assign Out_data  = r_out_data;
  assign Out_index = r_beat;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_array_result_drain.sv
// Bench for array_result_drain: table vectors, directed corner sequences and
// randomized tiles checked against a per-lane running-total model.
module tb_array_result_drain;

  localparam int LANES = 16;
  localparam longint MAXA = 64'h0000_0000_FFFF_FFFF;

  logic         Clk, Rst, In_valid, In_ready, In_last, Out_valid, Out_ready, Out_last, Overflow;
  logic [511:0] In_data;
  logic [4:0]   Shift;
  logic [31:0]  Out_data;
  logic [1:0]   Out_index;

  array_result_drain dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_ready(In_ready), .In_data(In_data),
    .In_last(In_last), .Shift(Shift), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_data(Out_data), .Out_index(Out_index), .Out_last(Out_last), .Overflow(Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] pass_lanes [LANES];
  longint      m_tot [LANES];
  bit          m_first = 1'b1;
  int          m_shift = 0;
  logic [31:0] cap_beat0, cap_beat3;
  logic        cap_ovf;

  typedef struct {
    int          npass;
    logic [31:0] base;
    logic [31:0] step;
    logic [4:0]  shift;
    logic [7:0]  exp0;
    logic [7:0]  exp15;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic longint req(input longint tot, input int s);
    longint a, r;
    a = (tot > MAXA) ? MAXA : tot;
    r = (s == 0) ? a : ((a + (64'sd1 <<< (s - 1))) >>> s);
    return (r > 255) ? 255 : r;
  endfunction

  function automatic logic [31:0] exp_beat(input int c);
    logic [31:0] v;
    for (int l = 0; l < 4; l++) v[l*8 +: 8] = 8'(req(m_tot[c*4 + l], m_shift));
    return v;
  endfunction

  function automatic bit model_ovf();
    for (int i = 0; i < LANES; i++) if (m_tot[i] > MAXA) return 1'b1;
    return 1'b0;
  endfunction

  task automatic junk_inputs();
    for (int i = 0; i < LANES; i++) In_data[i*32 +: 32] = $urandom;
    In_last = 1'($urandom_range(0, 1));
    Shift   = 5'($urandom_range(0, 31));
  endtask

  // Called at a negedge while the DUT is accumulating.
  task automatic send_pass(input bit last, input logic [4:0] sh, input int gap);
    In_valid = 1'b0;
    repeat (gap) @(negedge Clk);
    chk("in_ready_accum", 64'(In_ready), 64'd1);
    for (int i = 0; i < LANES; i++) In_data[i*32 +: 32] = pass_lanes[i];
    In_valid = 1'b1;
    In_last  = last;
    Shift    = sh;
    @(posedge Clk);
    @(negedge Clk);
    In_valid = 1'b0;
    junk_inputs();
    for (int i = 0; i < LANES; i++)
      m_tot[i] = (m_first ? 64'sd0 : m_tot[i]) + longint'(pass_lanes[i]);
    m_first = 1'b0;
    if (last) m_shift = int'(sh);
    chk("valid_after_pass", 64'(Out_valid), 64'(last));
    chk("ovf_after_pass", 64'(Overflow), 64'(model_ovf()));
  endtask

  // Called at the negedge after the last pass; drains or aborts the tile.
  task automatic drain(input int hold_beat, input int hold_n, input int abort_beat, input bit rnd);
    int beat = 0;
    int held = 0;
    int cyc  = 0;
    logic [31:0] hold_data = '0;
    while (beat < 4) begin
      if (cyc > 100) begin
        n_checks++;
        $display("FAIL drain_timeout: got beat %0d expected 4", beat);
        break;
      end
      if (beat == abort_beat) begin
        Out_ready = 1'b0;
        In_valid  = 1'b0;
        Rst       = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        m_first = 1'b1;
        chk("abort_out_valid", 64'(Out_valid), 64'd0);
        chk("abort_in_ready", 64'(In_ready), 64'd1);
        chk("abort_overflow", 64'(Overflow), 64'd0);
        chk("abort_index", 64'(Out_index), 64'd0);
        return;
      end
      chk("beat_valid", 64'(Out_valid), 64'd1);
      chk("beat_index", 64'(Out_index), 64'(beat));
      chk("beat_last", 64'(Out_last), 64'(beat == 3));
      chk("beat_in_ready", 64'(In_ready), 64'd0);
      chk("beat_data", 64'(Out_data), 64'(exp_beat(beat)));
      chk("beat_ovf", 64'(Overflow), 64'(model_ovf()));
      if (beat == 0) cap_beat0 = Out_data;
      if (beat == 3) cap_beat3 = Out_data;
      cap_ovf = Overflow;
      if (beat == hold_beat && held < hold_n) begin
        if (held > 0) chk("bp_hold_data", 64'(Out_data), 64'(hold_data));
        else hold_data = Out_data;
        Out_ready = 1'b0;
        held++;
      end else begin
        Out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
      In_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      junk_inputs();
      @(posedge Clk);
      if (Out_ready) beat++;
      @(negedge Clk);
      cyc++;
    end
    Out_ready = 1'b0;
    In_valid  = 1'b0;
    chk("post_drain_valid", 64'(Out_valid), 64'd0);
    chk("post_drain_in_ready", 64'(In_ready), 64'd1);
    m_first = 1'b1;
  endtask

  task automatic fill(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < LANES; i++) pass_lanes[i] = base + step * 32'(i);
  endtask

  initial begin
    vecs[0] = '{1, 32'd0,          32'd16, 5'd0,  8'd0,   8'd240, 1'b0};
    vecs[1] = '{3, 32'd100,        32'd0,  5'd2,  8'd75,  8'd75,  1'b0};
    vecs[2] = '{1, 32'd300,        32'd0,  5'd0,  8'd255, 8'd255, 1'b0};
    vecs[3] = '{2, 32'h8000_0000,  32'd0,  5'd0,  8'd255, 8'd255, 1'b1};
    vecs[4] = '{1, 32'd1000,       32'd1,  5'd3,  8'd125, 8'd127, 1'b0};
    vecs[5] = '{2, 32'hFFFF_FFFF,  32'd0,  5'd31, 8'd2,   8'd2,   1'b1};
    vecs[6] = '{4, 32'd10,         32'd2,  5'd1,  8'd20,  8'd80,  1'b0};

    Rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0; In_last = 1'b0; Shift = '0; In_data = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_in_ready", 64'(In_ready), 64'd1);
    chk("rst_out_valid", 64'(Out_valid), 64'd0);
    chk("rst_out_last", 64'(Out_last), 64'd0);
    chk("rst_out_index", 64'(Out_index), 64'd0);
    chk("rst_out_data", 64'(Out_data), 64'd0);
    chk("rst_overflow", 64'(Overflow), 64'd0);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].base, vecs[v].step);
      for (int p = 0; p < vecs[v].npass; p++) send_pass(p == vecs[v].npass - 1, vecs[v].shift, 0);
      drain(-1, 0, -1, 1'b0);
      chk("vec_lane0", 64'(cap_beat0[7:0]), 64'(vecs[v].exp0));
      chk("vec_lane15", 64'(cap_beat3[31:24]), 64'(vecs[v].exp15));
      chk("vec_ovf", 64'(cap_ovf), 64'(vecs[v].exp_ovf));
    end

    // Rounding and clamping on a single pass.
    fill(32'd0, 32'd0);
    pass_lanes[0] = 32'd5; pass_lanes[1] = 32'd6; pass_lanes[2] = 32'd1023;
    send_pass(1'b1, 5'd2, 1);
    drain(-1, 0, -1, 1'b0);
    chk("round_beat0", 64'(cap_beat0), 64'h00FF_0201);

    // Accumulator carry saturates, then the next tile's first pass clears Overflow.
    fill(32'd0, 32'd0);
    pass_lanes[0] = 32'hFFFF_FFF0;
    send_pass(1'b0, 5'd0, 0);
    pass_lanes[0] = 32'h20;
    send_pass(1'b1, 5'd0, 0);
    drain(-1, 0, -1, 1'b0);
    chk("acc_ovf_lane0", 64'(cap_beat0[7:0]), 64'd255);
    chk("acc_ovf_flag", 64'(cap_ovf), 64'd1);
    fill(32'd3, 32'd1);
    send_pass(1'b0, 5'd0, 0);
    chk("ovf_cleared_first_pass", 64'(Overflow), 64'd0);
    send_pass(1'b1, 5'd0, 0);
    drain(-1, 0, -1, 1'b0);

    // Backpressure held for three cycles on beat 1.
    fill(32'd20, 32'd3);
    send_pass(1'b1, 5'd0, 0);
    drain(1, 3, -1, 1'b0);

    // Reset during beat 2 of an overflowing tile, then a clean tile.
    fill(32'hFFFF_FFFF, 32'd0);
    send_pass(1'b0, 5'd0, 0);
    send_pass(1'b1, 5'd0, 0);
    drain(-1, 0, 2, 1'b0);
    fill(32'd7, 32'd0);
    send_pass(1'b1, 5'd0, 0);
    drain(-1, 0, -1, 1'b0);
    chk("post_abort_beat0", 64'(cap_beat0), 64'h0707_0707);
    chk("post_abort_beat3", 64'(cap_beat3), 64'h0707_0707);

    // Randomized tiles with gaps, backpressure and ignored traffic during drain.
    for (int t = 0; t < 40; t++) begin
      int np;
      logic [4:0] sh;
      np = $urandom_range(1, 4);
      sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      for (int p = 0; p < np; p++) begin
        for (int i = 0; i < LANES; i++)
          pass_lanes[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2000));
        send_pass(p == np - 1, sh, $urandom_range(0, 2));
      end
      drain(-1, 0, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
